hs_ram_arbiter: RTL and testbench

HS_RAM_ARBITER -- requirements
Module: hs_ram_arbiter

---
 rtl/hs_ram_arbiter.sv | 154 +++++++++++++++
 tb/tb_hs_ram_arbiter.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hs_ram_arbiter.sv
// hs_ram_arbiter: shares one single-port synchronous RAM between the CPU and
// the hiscore logic. The CPU owns the RAM normally. A pause request drains
// the bus for GUARD idle cycles, then hands the RAM to the hiscore side until
// the pause is released.
module hs_ram_arbiter #(
    parameter int AW    = 16,
    parameter int DW    = 8,
    parameter int GUARD = 4
) (
    input  logic          clk_sys,
    input  logic          reset_n,
    // CPU side
    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    output logic [DW-1:0] cpu_rdata,
    output logic          cpu_ack,
    // hiscore side
    input  logic          hs_req,
    input  logic          hs_we,
    input  logic [AW-1:0] hs_addr,
    input  logic [DW-1:0] hs_wdata,
    output logic [DW-1:0] hs_rdata,
    output logic          hs_ack,
    // pause handshake
    input  logic          pause_req,
    output logic          pause_cpu,
    output logic          paused,
    // RAM port (1-cycle read latency)
    output logic [AW-1:0] ram_addr,
    output logic          ram_we,
    output logic [DW-1:0] ram_wdata,
    input  logic [DW-1:0] ram_rdata
);

    // GUARD-1 must fit in the drain counter; GUARD=1 still needs one bit.
    localparam int            CW       = (GUARD > 1) ? $clog2(GUARD) : 1;
    localparam logic [CW-1:0] CNT_LOAD = CW'(GUARD - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CPU_ISS,
        S_CPU_DAT,
        S_DRAIN,
        S_PAUSED,
        S_HS_ISS,
        S_HS_DAT
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [DW-1:0] cpu_rdata_q, cpu_rdata_d;
    logic [DW-1:0] hs_rdata_q, hs_rdata_d;

    // State, drain counter and held read data; reset abandons any access.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            cpu_rdata_q <= '0;
            hs_rdata_q  <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            cpu_rdata_q <= cpu_rdata_d;
            hs_rdata_q  <= hs_rdata_d;
        end
    end

    // Next-state logic and RAM/ack outputs. Read data is passed straight
    // through in the DAT cycle so it is valid alongside the ack, and is
    // captured at the same time so it holds until the next ack.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        cpu_rdata_d = cpu_rdata_q;
        hs_rdata_d  = hs_rdata_q;
        ram_addr    = cpu_addr;
        ram_wdata   = cpu_wdata;
        ram_we      = 1'b0;
        cpu_ack     = 1'b0;
        hs_ack      = 1'b0;
        cpu_rdata   = cpu_rdata_q;
        hs_rdata    = hs_rdata_q;

        case (state_q)
            S_IDLE: begin
                // A pause wins over a simultaneous CPU request, which stays pending.
                if (pause_req) begin
                    state_d = S_DRAIN;
                    cnt_d   = CNT_LOAD;
                end else if (cpu_req) begin
                    state_d = S_CPU_ISS;
                end
            end
            S_CPU_ISS: begin
                ram_we  = cpu_we;
                state_d = S_CPU_DAT;
            end
            S_CPU_DAT: begin
                cpu_ack     = 1'b1;
                cpu_rdata   = ram_rdata;
                cpu_rdata_d = ram_rdata;
                if (pause_req) begin
                    state_d = S_DRAIN;
                    cnt_d   = CNT_LOAD;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_DRAIN: begin
                // Dropping the pause before the guard expires aborts the drain.
                if (!pause_req) begin
                    state_d = S_IDLE;
                end else if (cnt_q == '0) begin
                    state_d = S_PAUSED;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            S_PAUSED: begin
                if (hs_req) begin
                    state_d = S_HS_ISS;
                end else if (!pause_req) begin
                    state_d = S_IDLE;
                end
            end
            S_HS_ISS: begin
                ram_addr  = hs_addr;
                ram_wdata = hs_wdata;
                ram_we    = hs_we;
                state_d   = S_HS_DAT;
            end
            S_HS_DAT: begin
                ram_addr   = hs_addr;
                ram_wdata  = hs_wdata;
                hs_ack     = 1'b1;
                hs_rdata   = ram_rdata;
                hs_rdata_d = ram_rdata;
                state_d    = S_PAUSED;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign pause_cpu = pause_req |
                       (state_q == S_DRAIN)  | (state_q == S_PAUSED) |
                       (state_q == S_HS_ISS) | (state_q == S_HS_DAT);
    assign paused    = (state_q == S_PAUSED);

endmodule

// File: tb/tb_hs_ram_arbiter.sv
// Directed testbench for hs_ram_arbiter with a behavioural synchronous RAM.
module tb_hs_ram_arbiter;

    localparam int AW    = 16;
    localparam int DW    = 8;
    localparam int GUARD = 4;

    logic          clk_sys = 1'b0;
    logic          reset_n;
    logic          cpu_req, cpu_we;
    logic [AW-1:0] cpu_addr;
    logic [DW-1:0] cpu_wdata, cpu_rdata;
    logic          cpu_ack;
    logic          hs_req, hs_we;
    logic [AW-1:0] hs_addr;
    logic [DW-1:0] hs_wdata, hs_rdata;
    logic          hs_ack;
    logic          pause_req, pause_cpu, paused;
    logic [AW-1:0] ram_addr;
    logic          ram_we;
    logic [DW-1:0] ram_wdata;
    logic [DW-1:0] ram_rdata;

    int n_checks = 0;
    int n_fail   = 0;

    int we_cnt     = 0;
    int cack_cnt   = 0;
    int hack_cnt   = 0;
    int paused_cnt = 0;

    logic [DW-1:0] mem [0:(1<<AW)-1];
    logic          mem_init = 1'b0;

    hs_ram_arbiter #(.AW(AW), .DW(DW), .GUARD(GUARD)) dut (
        .clk_sys  (clk_sys),
        .reset_n  (reset_n),
        .cpu_req  (cpu_req),
        .cpu_we   (cpu_we),
        .cpu_addr (cpu_addr),
        .cpu_wdata(cpu_wdata),
        .cpu_rdata(cpu_rdata),
        .cpu_ack  (cpu_ack),
        .hs_req   (hs_req),
        .hs_we    (hs_we),
        .hs_addr  (hs_addr),
        .hs_wdata (hs_wdata),
        .hs_rdata (hs_rdata),
        .hs_ack   (hs_ack),
        .pause_req(pause_req),
        .pause_cpu(pause_cpu),
        .paused   (paused),
        .ram_addr (ram_addr),
        .ram_we   (ram_we),
        .ram_wdata(ram_wdata),
        .ram_rdata(ram_rdata)
    );

    always #5 clk_sys = ~clk_sys;

    // Single-port synchronous RAM, 1-cycle read latency, preloaded at 0x8010.
    always @(posedge clk_sys) begin
        if (!mem_init) begin
            mem[16'h8010] <= 8'h5A;
            mem_init      <= 1'b1;
        end else if (ram_we) begin
            mem[ram_addr] <= ram_wdata;
        end
        ram_rdata <= mem[ram_addr];
    end

    // Event counters sampled mid-cycle.
    always @(negedge clk_sys) begin
        if (ram_we === 1'b1)  we_cnt++;
        if (cpu_ack === 1'b1) cack_cnt++;
        if (hs_ack === 1'b1)  hack_cnt++;
        if (paused === 1'b1)  paused_cnt++;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_sys);
        #2;
    endtask

    // Present a request on one side, wait (bounded) for its ack, return the
    // number of clock edges taken and the read data seen with the ack.
    task automatic xfer(input bit hs, input bit we, input logic [AW-1:0] addr,
                        input logic [DW-1:0] wd, input int budget,
                        output int lat, output logic [DW-1:0] rd);
        lat = 0;
        if (hs) begin
            hs_req = 1'b1; hs_we = we; hs_addr = addr; hs_wdata = wd;
        end else begin
            cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wd;
        end
        #1;
        while (((hs ? hs_ack : cpu_ack) !== 1'b1) && (lat < budget)) begin
            tick();
            lat++;
        end
        rd = hs ? hs_rdata : cpu_rdata;
        if (hs) hs_req = 1'b0;
        else    cpu_req = 1'b0;
        tick();
    endtask

    initial begin
        int            lat;
        int            snap_we, snap_cack, snap_hack, snap_paused;
        logic [DW-1:0] rd;

        reset_n   = 1'b0;
        cpu_req   = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
        hs_req    = 1'b0; hs_we  = 1'b0; hs_addr  = '0; hs_wdata  = '0;
        pause_req = 1'b0;

        // ---- reset state
        repeat (2) tick();
        check("rst_cpu_ack",   32'(cpu_ack),   32'h0);
        check("rst_hs_ack",    32'(hs_ack),    32'h0);
        check("rst_ram_we",    32'(ram_we),    32'h0);
        check("rst_cpu_rdata", 32'(cpu_rdata), 32'h0);
        check("rst_hs_rdata",  32'(hs_rdata),  32'h0);
        check("rst_paused",    32'(paused),    32'h0);
        check("rst_pause_cpu_lo", 32'(pause_cpu), 32'h0);
        pause_req = 1'b1; #1;
        check("rst_pause_cpu_hi", 32'(pause_cpu), 32'h1);
        pause_req = 1'b0; #1;
        reset_n = 1'b1;
        tick();

        // ---- CPU read of 0x8010, latency and data
        snap_we  = we_cnt;
        cpu_req  = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h8010;
        #1;
        check("rd_idle_ack", 32'(cpu_ack), 32'h0);
        tick();
        check("rd_iss_ack",  32'(cpu_ack),  32'h0);
        check("rd_iss_addr", 32'(ram_addr), 32'h8010);
        check("rd_iss_we",   32'(ram_we),   32'h0);
        tick();
        check("rd_dat_ack",   32'(cpu_ack),   32'h1);
        check("rd_dat_rdata", 32'(cpu_rdata), 32'h5A);
        cpu_req = 1'b0;
        tick();
        check("rd_after_ack",  32'(cpu_ack),   32'h0);
        check("rd_hold_rdata", 32'(cpu_rdata), 32'h5A);
        check("rd_no_we",      32'(we_cnt - snap_we), 32'h0);

        // ---- CPU write 0x8011 <= 0xA5 then read back
        snap_we = we_cnt;
        xfer(1'b0, 1'b1, 16'h8011, 8'hA5, 10, lat, rd);
        check("wr_latency", 32'(lat), 32'd2);
        check("wr_we_once", 32'(we_cnt - snap_we), 32'd1);
        xfer(1'b0, 1'b0, 16'h8011, 8'h00, 10, lat, rd);
        check("wrrd_latency", 32'(lat), 32'd2);
        check("wrrd_data",    32'(rd),  32'hA5);
        check("wrrd_we_once", 32'(we_cnt - snap_we), 32'd1);

        // ---- pause raised during CPU_ISS
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h8010;
        #1;
        tick();
        pause_req = 1'b1;
        #1;
        check("pz_iss_pause_cpu", 32'(pause_cpu), 32'h1);
        check("pz_iss_paused",    32'(paused),    32'h0);
        tick();
        check("pz_dat_ack",       32'(cpu_ack),   32'h1);
        check("pz_dat_rdata",     32'(cpu_rdata), 32'h5A);
        check("pz_dat_pause_cpu", 32'(pause_cpu), 32'h1);
        cpu_req = 1'b0;
        tick();
        check("pz_drain_paused",    32'(paused),    32'h0);
        check("pz_drain_pause_cpu", 32'(pause_cpu), 32'h1);
        lat = 0;
        while ((paused !== 1'b1) && (lat < 10)) begin
            tick();
            lat++;
        end
        check("pz_guard_cycles", 32'(lat), 32'(GUARD));

        // ---- hiscore write/read while paused, CPU held off
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h8010;
        snap_cack = cack_cnt;
        xfer(1'b1, 1'b1, 16'h8100, 8'h33, 10, lat, rd);
        check("hs_wr_latency", 32'(lat), 32'd2);
        xfer(1'b1, 1'b0, 16'h8100, 8'h00, 10, lat, rd);
        check("hs_rd_latency", 32'(lat), 32'd2);
        check("hs_rd_data",    32'(rd),  32'h33);
        check("hs_rd_hold",    32'(hs_rdata), 32'h33);
        check("hs_cpu_no_ack", 32'(cack_cnt - snap_cack), 32'h0);
        check("hs_paused",     32'(paused), 32'h1);
        pause_req = 1'b0;
        #1;
        check("unpz_still_paused", 32'(paused),    32'h1);
        check("unpz_pause_cpu",    32'(pause_cpu), 32'h1);
        tick();
        check("unpz_idle_paused",    32'(paused),    32'h0);
        check("unpz_idle_pause_cpu", 32'(pause_cpu), 32'h0);
        check("unpz_idle_ack",       32'(cpu_ack),   32'h0);
        lat = 0;
        while ((cpu_ack !== 1'b1) && (lat < 10)) begin
            tick();
            lat++;
        end
        check("unpz_cpu_latency", 32'(lat), 32'd2);
        check("unpz_cpu_rdata",   32'(cpu_rdata), 32'h5A);
        cpu_req = 1'b0;
        tick();

        // ---- short pause pulse aborts the drain; pending CPU request served
        snap_paused = paused_cnt;
        cpu_req   = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h8010;
        pause_req = 1'b1;
        #1;
        check("pulse_pause_cpu", 32'(pause_cpu), 32'h1);
        tick();
        check("pulse_d0_ack",    32'(cpu_ack), 32'h0);
        tick();
        pause_req = 1'b0;
        #1;
        lat = 0;
        while ((cpu_ack !== 1'b1) && (lat < 10)) begin
            tick();
            lat++;
        end
        check("pulse_cpu_latency", 32'(lat), 32'd3);
        check("pulse_cpu_rdata",   32'(cpu_rdata), 32'h5A);
        check("pulse_never_paused", 32'(paused_cnt - snap_paused), 32'h0);
        cpu_req = 1'b0;
        tick();

        // ---- hs request outside PAUSED stays pending until PAUSED
        snap_hack = hack_cnt;
        hs_req = 1'b1; hs_we = 1'b1; hs_addr = 16'h8102; hs_wdata = 8'h77;
        repeat (3) tick();
        check("hspend_no_ack", 32'(hack_cnt - snap_hack), 32'h0);
        check("hspend_paused", 32'(paused), 32'h0);
        pause_req = 1'b1;
        #1;
        lat = 0;
        while ((hs_ack !== 1'b1) && (lat < 20)) begin
            tick();
            lat++;
        end
        check("hspend_latency", 32'(lat), 32'(GUARD + 3));
        hs_req = 1'b0;
        tick();
        xfer(1'b1, 1'b0, 16'h8102, 8'h00, 10, lat, rd);
        check("hspend_readback", 32'(rd), 32'h77);

        // ---- reset asserted in HS_DAT
        snap_hack = hack_cnt;
        hs_req = 1'b1; hs_we = 1'b0; hs_addr = 16'h8100;
        #1;
        tick();
        tick();
        reset_n = 1'b0;
        #1;
        check("rstmid_hs_ack",    32'(hs_ack),    32'h0);
        check("rstmid_hs_rdata",  32'(hs_rdata),  32'h0);
        check("rstmid_cpu_rdata", 32'(cpu_rdata), 32'h0);
        check("rstmid_paused",    32'(paused),    32'h0);
        check("rstmid_ram_we",    32'(ram_we),    32'h0);
        check("rstmid_pause_cpu", 32'(pause_cpu), 32'h1);
        tick();
        check("rstmid_no_hs_ack", 32'(hack_cnt - snap_hack), 32'h0);
        hs_req = 1'b0; pause_req = 1'b0;
        reset_n = 1'b1;
        #1;
        check("rstrel_paused",    32'(paused),    32'h0);
        check("rstrel_pause_cpu", 32'(pause_cpu), 32'h0);
        tick();
        xfer(1'b0, 1'b0, 16'h8010, 8'h00, 10, lat, rd);
        check("rstrel_cpu_latency", 32'(lat), 32'd2);
        check("rstrel_cpu_rdata",   32'(rd),  32'h5A);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
